// File: rtl/frog_pkg.sv
// ---------------------------------------------------------------------------
// frog_pkg
// Shared definitions for the frog-movement controller:
//   - FSM state encoding (STATE_INIT..STATE_OVER) and the state_t enum
//   - shiftselection codes for the point-type register
//   - default playfield rows and starting lives
//   - saturating level increment helper
// No ports (package).
// ---------------------------------------------------------------------------
package frog_pkg;

   localparam logic [2:0] STATE_INIT    = 3'd0;
   localparam logic [2:0] STATE_PLAY    = 3'd1;
   localparam logic [2:0] STATE_RELEASE = 3'd2;
   localparam logic [2:0] STATE_HIT     = 3'd3;
   localparam logic [2:0] STATE_WIN     = 3'd4;
   localparam logic [2:0] STATE_OVER    = 3'd5;

   typedef enum logic [2:0] {
      ST_INIT    = STATE_INIT,
      ST_PLAY    = STATE_PLAY,
      ST_RELEASE = STATE_RELEASE,
      ST_HIT     = STATE_HIT,
      ST_WIN     = STATE_WIN,
      ST_OVER    = STATE_OVER
   } state_t;

   localparam logic [1:0] SHIFT_LEFT  = 2'b01;
   localparam logic [1:0] SHIFT_RIGHT = 2'b10;
   localparam logic [1:0] SHIFT_HOLD  = 2'b00;

   localparam int DEFAULT_ROWS  = 12;
   localparam int DEFAULT_LIVES = 3;

   function automatic logic [3:0] level_inc(input logic [3:0] lvl);
      return (lvl == 4'hF) ? lvl : lvl + 4'd1;
   endfunction

endpackage

// File: rtl/sc_counter_frogrow.sv
// ---------------------------------------------------------------------------
// sc_counter_frogrow
// Frog row up/down counter. Clear has priority over inc, inc over dec.
// Counting saturates at row 0 and at row ROWS-1.
// Ports:
//   clk_sys       in   clock
//   rst           in   asynchronous active-high reset (row -> 0)
//   clr/inc/dec   in   row to 0 / row+1 / row-1
//   row           out  current row
//   at_floor      out  row == 0
//   at_ceiling    out  row == ROWS-1 (goal row)
//   near_ceiling  out  row == ROWS-2 (next up reaches the goal)
// ---------------------------------------------------------------------------
module sc_counter_frogrow
   import frog_pkg::*;
#(
   parameter int ROW_WIDTH = 4,
   parameter int ROWS      = DEFAULT_ROWS
) (
   input  logic                 clk_sys,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 inc,
   input  logic                 dec,
   output logic [ROW_WIDTH-1:0] row,
   output logic                 at_floor,
   output logic                 at_ceiling,
   output logic                 near_ceiling
);

   logic [ROW_WIDTH-1:0] row_q, row_d;

   assign at_floor     = (row_q == '0);
   assign at_ceiling   = (row_q == ROW_WIDTH'(ROWS - 1));
   assign near_ceiling = (row_q == ROW_WIDTH'(ROWS - 2));
   assign row          = row_q;

   always_comb begin
      row_d = row_q;
      if (clr) begin
         row_d = '0;
      end else if (inc && !at_ceiling) begin
         row_d = row_q + 1'b1;
      end else if (dec && !at_floor) begin
         row_d = row_q - 1'b1;
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         row_q <= '0;
      end else begin
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/sc_statemachine_frog.sv
// ---------------------------------------------------------------------------
// sc_statemachine_frog
// Frog-movement controller. Drives the active-low controls of the frog
// point-type register from buttons and game events, and owns the row,
// lives and level counters. All outputs are registered (Moore).
// Optional macro: FROG_AUTOREPEAT_EN -- auto-repeat of a held direction
// every REPEAT_TICKS clocks while waiting for release.
// Ports:
//   SC_STATEMACHINEFROG_CLOCK_50        in   clock
//   SC_STATEMACHINEFROG_RESET_InHigh    in   async active-high reset
//   *_left/right/up/down_InLow          in   debounced buttons, active low
//   *_start_InLow                       in   restart from game over
//   *_collision_InHigh                  in   frog overlaps an obstacle
//   *_point_InBUS                       in   point register value
//   *_clear/changeP/load0/load1_OutLow  out  register strobes, one clock
//   *_shiftselection_Out                out  01 left, 10 right, 00 hold
//   *_row_OutBUS / lives_OutBUS / level_OutBUS / gameover_OutHigh  out
//
// state   | meaning
// INIT    | clear register, reload row/lives/level
// PLAY    | waiting for a move or a collision
// RELEASE | move done, waiting for all direction buttons released
// HIT     | collision: respawn (load0) or run out of lives
// WIN     | goal reached: next-level spawn (load1), level+1
// OVER    | game over pattern shown, waiting for start
// ---------------------------------------------------------------------------
module sc_statemachine_frog
   import frog_pkg::*;
#(
   parameter int POINT_WIDTH  = 8,
   parameter int ROW_WIDTH    = 4,
   parameter int ROWS         = DEFAULT_ROWS,
   parameter int LIVES        = DEFAULT_LIVES,
   parameter int REPEAT_TICKS = 25_000_000
) (
   input  logic                   SC_STATEMACHINEFROG_CLOCK_50,
   input  logic                   SC_STATEMACHINEFROG_RESET_InHigh,
   input  logic                   SC_STATEMACHINEFROG_left_InLow,
   input  logic                   SC_STATEMACHINEFROG_right_InLow,
   input  logic                   SC_STATEMACHINEFROG_up_InLow,
   input  logic                   SC_STATEMACHINEFROG_down_InLow,
   input  logic                   SC_STATEMACHINEFROG_start_InLow,
   input  logic                   SC_STATEMACHINEFROG_collision_InHigh,
   input  logic [POINT_WIDTH-1:0] SC_STATEMACHINEFROG_point_InBUS,
   output logic                   SC_STATEMACHINEFROG_clear_OutLow,
   output logic                   SC_STATEMACHINEFROG_changeP_OutLow,
   output logic                   SC_STATEMACHINEFROG_load0_OutLow,
   output logic                   SC_STATEMACHINEFROG_load1_OutLow,
   output logic [1:0]             SC_STATEMACHINEFROG_shiftselection_Out,
   output logic [ROW_WIDTH-1:0]   SC_STATEMACHINEFROG_row_OutBUS,
   output logic [1:0]             SC_STATEMACHINEFROG_lives_OutBUS,
   output logic [3:0]             SC_STATEMACHINEFROG_level_OutBUS,
   output logic                   SC_STATEMACHINEFROG_gameover_OutHigh
);

   logic clk_sys, rst;
   assign clk_sys = SC_STATEMACHINEFROG_CLOCK_50;
   assign rst     = SC_STATEMACHINEFROG_RESET_InHigh;

   logic btn_up, btn_down, btn_left, btn_right, collision, start, any_btn;
   logic [3:0] btn_vec;
   assign btn_up    = ~SC_STATEMACHINEFROG_up_InLow;
   assign btn_down  = ~SC_STATEMACHINEFROG_down_InLow;
   assign btn_left  = ~SC_STATEMACHINEFROG_left_InLow;
   assign btn_right = ~SC_STATEMACHINEFROG_right_InLow;
   assign start     = ~SC_STATEMACHINEFROG_start_InLow;
   assign collision = SC_STATEMACHINEFROG_collision_InHigh;
   assign btn_vec   = {btn_up, btn_down, btn_left, btn_right};
   assign any_btn   = |btn_vec;

   // Wrap-around is blocked by looking only at the two edge columns.
   logic at_left_edge, at_right_edge;
   assign at_left_edge  = SC_STATEMACHINEFROG_point_InBUS[POINT_WIDTH-1];
   assign at_right_edge = SC_STATEMACHINEFROG_point_InBUS[0];
   logic unused_point;
   assign unused_point = ^SC_STATEMACHINEFROG_point_InBUS[POINT_WIDTH-2:1];

   state_t     state_q, state_d;
   logic       clear_q, clear_d;
   logic       changep_q, changep_d;
   logic       load0_q, load0_d;
   logic       load1_q, load1_d;
   logic [1:0] shift_q, shift_d;
   logic [1:0] lives_q, lives_d;
   logic [3:0] level_q, level_d;
   logic       gameover_q, gameover_d;

   logic row_clr, row_inc, row_dec;
   logic row_at_floor, row_at_ceiling, row_near_ceiling;
   logic [ROW_WIDTH-1:0] row;
   logic do_move, rep_fire;

   sc_counter_frogrow #(
      .ROW_WIDTH (ROW_WIDTH),
      .ROWS      (ROWS)
   ) u_row (
      .clk_sys      (clk_sys),
      .rst          (rst),
      .clr          (row_clr),
      .inc          (row_inc),
      .dec          (row_dec),
      .row          (row),
      .at_floor     (row_at_floor),
      .at_ceiling   (row_at_ceiling),
      .near_ceiling (row_near_ceiling)
   );

`ifdef FROG_AUTOREPEAT_EN
   logic [24:0] rep_cnt_q, rep_cnt_d;
   logic [3:0]  btn_prev_q;

   // Counts only while the exact same button set stays held in RELEASE;
   // any change of the set restarts the period.
   always_comb begin
      rep_fire  = 1'b0;
      rep_cnt_d = '0;
      if (state_q == ST_RELEASE && any_btn && btn_vec == btn_prev_q) begin
         if (rep_cnt_q == 25'(REPEAT_TICKS - 1)) begin
            rep_fire = 1'b1;
         end else begin
            rep_cnt_d = rep_cnt_q + 25'd1;
         end
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         rep_cnt_q  <= '0;
         btn_prev_q <= '0;
      end else begin
         rep_cnt_q  <= rep_cnt_d;
         btn_prev_q <= btn_vec;
      end
   end
`else
   localparam int UNUSED_REPEAT_TICKS = REPEAT_TICKS;
   assign rep_fire = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      clear_d   = 1'b1;
      changep_d = 1'b1;
      load0_d   = 1'b1;
      load1_d   = 1'b1;
      shift_d   = SHIFT_HOLD;
      lives_d   = lives_q;
      level_d   = level_q;
      row_clr   = 1'b0;
      row_inc   = 1'b0;
      row_dec   = 1'b0;
      do_move   = 1'b0;

      case (state_q)
         ST_INIT: begin
            clear_d = 1'b0;
            row_clr = 1'b1;
            lives_d = 2'(LIVES);
            level_d = 4'd0;
            state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (collision) begin
               state_d = ST_HIT;
            end else if (any_btn) begin
               do_move = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (collision) begin
               state_d = ST_HIT;
            end else if (!any_btn) begin
               state_d = ST_PLAY;
            end else if (rep_fire) begin
               do_move = 1'b1;
            end
         end
         ST_HIT: begin
            row_clr = 1'b1;
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
               changep_d = 1'b0;
               state_d   = ST_OVER;
            end else begin
               load0_d = 1'b0;
               state_d = ST_RELEASE;
            end
         end
         ST_WIN: begin
            load1_d = 1'b0;
            row_clr = 1'b1;
            level_d = level_inc(level_q);
            state_d = ST_RELEASE;
         end
         ST_OVER: begin
            if (start) begin
               state_d = ST_INIT;
            end
         end
         default: state_d = ST_INIT;
      endcase

      // Suppressed/ignored moves still end in RELEASE so a hold never
      // turns into a second move.
      if (do_move) begin
         state_d = ST_RELEASE;
         if (btn_up) begin
            row_inc = 1'b1;
            if (row_near_ceiling) begin
               state_d = ST_WIN;
            end
         end else if (btn_down) begin
            row_dec = 1'b1;
         end else if (btn_left) begin
            if (!at_left_edge) begin
               shift_d = SHIFT_LEFT;
            end
         end else if (btn_right) begin
            if (!at_right_edge) begin
               shift_d = SHIFT_RIGHT;
            end
         end
      end

      gameover_d = (state_d == ST_OVER);
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q    <= ST_INIT;
         clear_q    <= 1'b1;
         changep_q  <= 1'b1;
         load0_q    <= 1'b1;
         load1_q    <= 1'b1;
         shift_q    <= SHIFT_HOLD;
         lives_q    <= 2'(LIVES);
         level_q    <= 4'd0;
         gameover_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clear_q    <= clear_d;
         changep_q  <= changep_d;
         load0_q    <= load0_d;
         load1_q    <= load1_d;
         shift_q    <= shift_d;
         lives_q    <= lives_d;
         level_q    <= level_d;
         gameover_q <= gameover_d;
      end
   end

   assign SC_STATEMACHINEFROG_clear_OutLow       = clear_q;
   assign SC_STATEMACHINEFROG_changeP_OutLow     = changep_q;
   assign SC_STATEMACHINEFROG_load0_OutLow       = load0_q;
   assign SC_STATEMACHINEFROG_load1_OutLow       = load1_q;
   assign SC_STATEMACHINEFROG_shiftselection_Out = shift_q;
   assign SC_STATEMACHINEFROG_row_OutBUS         = row;
   assign SC_STATEMACHINEFROG_lives_OutBUS       = lives_q;
   assign SC_STATEMACHINEFROG_level_OutBUS       = level_q;
   assign SC_STATEMACHINEFROG_gameover_OutHigh   = gameover_q;

endmodule

// File: tb/tb_sc_statemachine_frog.sv
// ---------------------------------------------------------------------------
// tb_sc_statemachine_frog
// Directed bench for sc_statemachine_frog with an event-level game model
// checked every cycle, plus literal pulse-count / counter expectations.
// Builds with or without FROG_AUTOREPEAT_EN (REPEAT_TICKS = 10 here).
// ---------------------------------------------------------------------------
module tb_sc_statemachine_frog;

   localparam int ROWS = 12;
   localparam int LIVES = 3;
   localparam int REPEAT = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic b_left = 1'b1, b_right = 1'b1, b_up = 1'b1, b_down = 1'b1;
   logic start_n = 1'b1, coll = 1'b0;
   logic [7:0] point = 8'h10;

   logic       clear_n, changep_n, load0_n, load1_n, gameover;
   logic [1:0] shift, lives;
   logic [3:0] row, level;

   always #5 clk = ~clk;

   sc_statemachine_frog #(
      .POINT_WIDTH (8), .ROW_WIDTH (4), .ROWS (ROWS), .LIVES (LIVES),
      .REPEAT_TICKS (REPEAT)
   ) dut (
      .SC_STATEMACHINEFROG_CLOCK_50           (clk),
      .SC_STATEMACHINEFROG_RESET_InHigh       (rst),
      .SC_STATEMACHINEFROG_left_InLow         (b_left),
      .SC_STATEMACHINEFROG_right_InLow        (b_right),
      .SC_STATEMACHINEFROG_up_InLow           (b_up),
      .SC_STATEMACHINEFROG_down_InLow         (b_down),
      .SC_STATEMACHINEFROG_start_InLow        (start_n),
      .SC_STATEMACHINEFROG_collision_InHigh   (coll),
      .SC_STATEMACHINEFROG_point_InBUS        (point),
      .SC_STATEMACHINEFROG_clear_OutLow       (clear_n),
      .SC_STATEMACHINEFROG_changeP_OutLow     (changep_n),
      .SC_STATEMACHINEFROG_load0_OutLow       (load0_n),
      .SC_STATEMACHINEFROG_load1_OutLow       (load1_n),
      .SC_STATEMACHINEFROG_shiftselection_Out (shift),
      .SC_STATEMACHINEFROG_row_OutBUS         (row),
      .SC_STATEMACHINEFROG_lives_OutBUS       (lives),
      .SC_STATEMACHINEFROG_level_OutBUS       (level),
      .SC_STATEMACHINEFROG_gameover_OutHigh   (gameover)
   );

   // ---------------- game model (event flags + integer counters) --------
   bit init_due, hit_due, win_due, over, waiting;
   int m_row, m_lives, m_level, m_age;
   bit m_gameover;
   logic [3:0] m_prev, btn;
   logic e_clear, e_changep, e_load0, e_load1;
   logic [1:0] e_shift;

   task automatic model_move();
      waiting = 1;
      if (!b_up) begin
         m_row = m_row + 1;
         if (m_row == ROWS - 1) win_due = 1;
      end else if (!b_down) begin
         if (m_row > 0) m_row = m_row - 1;
      end else if (!b_left) begin
         if (!point[7]) e_shift = 2'b01;
      end else if (!b_right) begin
         if (!point[0]) e_shift = 2'b10;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         init_due = 1; hit_due = 0; win_due = 0; over = 0; waiting = 0;
         m_row = 0; m_lives = LIVES; m_level = 0; m_gameover = 0; m_age = 0;
         m_prev = 4'hF;
         e_clear = 1; e_changep = 1; e_load0 = 1; e_load1 = 1; e_shift = 2'b00;
      end else begin
         bit rep;
         btn = {b_up, b_down, b_left, b_right};
         e_clear = 1; e_changep = 1; e_load0 = 1; e_load1 = 1; e_shift = 2'b00;
         rep = 0;
`ifdef FROG_AUTOREPEAT_EN
         if (waiting && !init_due && !hit_due && !win_due && !over &&
             btn != 4'hF && btn == m_prev) begin
            m_age = m_age + 1;
            if (m_age == REPEAT) begin
               rep = 1;
               m_age = 0;
            end
         end else begin
            m_age = 0;
         end
`endif
         m_prev = btn;
         if (init_due) begin
            init_due = 0; waiting = 0;
            e_clear = 0; m_row = 0; m_lives = LIVES; m_level = 0;
         end else if (over) begin
            if (!start_n) begin
               over = 0; init_due = 1; m_gameover = 0;
            end
         end else if (hit_due) begin
            hit_due = 0; m_row = 0; m_lives = m_lives - 1;
            if (m_lives == 0) begin
               over = 1; m_gameover = 1; e_changep = 0;
            end else begin
               e_load0 = 0; waiting = 1;
            end
         end else if (win_due) begin
            win_due = 0; e_load1 = 0; m_row = 0; waiting = 1;
            if (m_level < 15) m_level = m_level + 1;
         end else if (coll) begin
            hit_due = 1;
         end else if (waiting) begin
            if (btn == 4'hF) waiting = 0;
            else if (rep) model_move();
         end else if (btn != 4'hF) begin
            model_move();
         end
      end
   end

   // ---------------- checking ------------------------------------------
   int n_tests = 0;
   int n_fail = 0;
   int c_clear, c_changep, c_load0, c_load1, c_sl, c_sr;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clr_counts();
      c_clear = 0; c_changep = 0; c_load0 = 0; c_load1 = 0; c_sl = 0; c_sr = 0;
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         n_tests++;
         if ({clear_n, changep_n, load0_n, load1_n, shift, row, lives, level, gameover} !==
             {e_clear, e_changep, e_load0, e_load1, e_shift, 4'(m_row), 2'(m_lives),
              4'(m_level), m_gameover}) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t got clr%b chg%b ld0%b ld1%b sh%b row%0d liv%0d lvl%0d go%b, expected clr%b chg%b ld0%b ld1%b sh%b row%0d liv%0d lvl%0d go%b",
                     $time, clear_n, changep_n, load0_n, load1_n, shift, row, lives, level,
                     gameover, e_clear, e_changep, e_load0, e_load1, e_shift, m_row,
                     m_lives, m_level, m_gameover);
         end
         if (!clear_n) c_clear++;
         if (!changep_n) c_changep++;
         if (!load0_n) c_load0++;
         if (!load1_n) c_load1++;
         if (shift == 2'b01) c_sl++;
         if (shift == 2'b10) c_sr++;
      end
   endtask

   task automatic press_up(input int n);
      repeat (n) begin
         b_up = 0; tick(2); b_up = 1; tick(3);
      end
   endtask

   task automatic pulse_coll();
      coll = 1; tick(1); coll = 0; tick(4);
   endtask

   initial begin
      clr_counts();
      tick(3);
      check("reset_clear", clear_n, 1);
      check("reset_shift", shift, 0);
      check("reset_lives", lives, 3);
      check("reset_gameover", gameover, 0);
      rst = 0;
      tick(1);
      check("init_clear_low", clear_n, 0);
      tick(1);
      check("init_clear_one_cycle", clear_n, 1);
      check("init_row", row, 0);
      check("init_lives", lives, 3);

      // left move, held 100 cycles
      point = 8'h10; clr_counts();
      b_left = 0; tick(100); b_left = 1; tick(3);
`ifdef FROG_AUTOREPEAT_EN
      check("left_hold_pulses", c_sl, 10);
`else
      check("left_hold_pulses", c_sl, 1);
`endif
      // left at the MSB edge is suppressed; RELEASE blocks a later move
      point = 8'h80; clr_counts();
      b_left = 0; tick(3); point = 8'h10; tick(3); b_left = 1; tick(3);
      check("left_edge_suppressed", c_sl, 0);

      // right at the LSB edge suppressed, then allowed
      point = 8'h01; clr_counts();
      b_right = 0; tick(2); b_right = 1; tick(3);
      check("right_edge_suppressed", c_sr, 0);
      point = 8'h10;
      b_right = 0; tick(2); b_right = 1; tick(3);
      check("right_move", c_sr, 1);

      // down at row 0 ignored
      b_down = 0; tick(2); b_down = 1; tick(3);
      check("down_floor", row, 0);

      // climb to the goal
      clr_counts();
      press_up(10);
      check("row_after_10_up", row, 10);
      check("no_win_yet", c_load1, 0);
      press_up(1);
      check("win_load1", c_load1, 1);
      check("win_row", row, 0);
      check("win_level", level, 1);

      press_up(2);
      b_down = 0; tick(2); b_down = 1; tick(3);
      check("up_up_down_row", row, 1);

      // collision together with a button: button discarded
      clr_counts();
      coll = 1; b_up = 0; tick(1);
      check("coll_beats_up_row", row, 1);
      coll = 0; b_up = 1; tick(4);
      check("hit1_lives", lives, 2);
      check("hit1_row", row, 0);
      check("hit1_load0", c_load0, 1);
      pulse_coll();
      check("hit2_lives", lives, 1);
      pulse_coll();
      check("hit3_lives", lives, 0);
      check("hit_load0_total", c_load0, 2);
      check("over_changep", c_changep, 1);
      check("over_flag", gameover, 1);

      press_up(1);
      check("over_ignores_up", row, 0);
      clr_counts();
      start_n = 0; tick(1); start_n = 1; tick(3);
      check("restart_clear", c_clear, 1);
      check("restart_lives", lives, 3);
      check("restart_gameover", gameover, 0);
      check("restart_level", level, 0);

      // right held 35 cycles
      point = 8'h10; clr_counts();
      b_right = 0; tick(35); b_right = 1; tick(3);
`ifdef FROG_AUTOREPEAT_EN
      check("right_repeat_pulses", c_sr, 4);
`else
      check("right_repeat_pulses", c_sr, 1);
`endif

      // asynchronous reset mid-game
      press_up(3);
      check("pre_reset_row", row, 3);
      @(posedge clk); #2 rst = 1; #1;
      check("async_reset_row", row, 0);
      check("async_reset_lives", lives, 3);
      tick(2); rst = 0; tick(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
